// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block width, feeder state encoding and the
// len(A)||len(C) block builder used by the GHASH feeder.
package gcm_pkg;

  localparam int GCM_BLK_W     = 128;
  localparam int GCM_BLK_BYTES = GCM_BLK_W / 8;

  typedef enum logic [2:0] {
    FEED_IDLE,
    FEED_START,
    FEED_AAD,
    FEED_DATA_ANN,
    FEED_DATA,
    FEED_LEN_ANN,
    FEED_LEN,
    FEED_WAIT_TAG
  } gcm_feed_state_t;

  // Byte counts in, bit lengths out: {len(A), len(C)} as two 64-bit fields.
  function automatic logic [GCM_BLK_W-1:0] gcm_len_block(input logic [63:0] aad_bytes,
                                                         input logic [63:0] data_bytes);
    return {aad_bytes << 3, data_bytes << 3};
  endfunction

endpackage

// File: rtl/gcm_byte_pad.sv
// Combinational MSB-first byte pad: keeps bytes [0..n_bytes-1] of a 128-bit
// block (byte 0 at [127:120]) and forces the rest to zero.
module gcm_byte_pad
  import gcm_pkg::*;
(
  input  logic [GCM_BLK_W-1:0] data,
  input  logic [4:0]           n_bytes,
  output logic [GCM_BLK_W-1:0] block
);

  always_comb begin
    block = '0;
    for (int i = 0; i < GCM_BLK_BYTES; i++) begin
      if (5'(i) < n_bytes) begin
        block[GCM_BLK_W-1-8*i -: 8] = data[GCM_BLK_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/gcm_ghash_feeder.sv
// GHASH feeder: pads AAD/ciphertext beats, counts lengths and sequences the
// gcm_ghash control pulses. Optional protocol checker: GCM_FEED_PROTO_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for op_start, busy=0
// START    | gh_start pulse out, pick AAD or straight to length block
// AAD      | taking AAD beats until a ciphertext beat shows up or in_last
// DATA_ANN | take held first data beat, present it twice (announce + absorb)
// DATA     | taking ciphertext beats until in_last
// LEN_ANN  | first gh_final cycle with len(A)||len(C)
// LEN      | second gh_final cycle
// WAIT_TAG | waiting for gh_tag_valid, then op_done
module gcm_ghash_feeder
  import gcm_pkg::*;
#(
  parameter int LEN_W = 36
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_start,
  input  logic                 op_empty,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [GCM_BLK_W-1:0] in_data,
  input  logic [4:0]           in_bytes,
  input  logic                 in_is_aad,
  input  logic                 in_last,
  output logic                 gh_start,
  output logic                 gh_aad_valid,
  output logic                 gh_data_valid,
  output logic                 gh_final,
  output logic [GCM_BLK_W-1:0] gh_block,
  input  logic                 gh_tag_valid,
  output logic                 busy,
  output logic                 op_done,
  output logic                 err
);

  gcm_feed_state_t      state_q;
  logic                 empty_q;
  logic                 ann_ph_q;
  logic                 ann_last_q;
  logic [LEN_W-1:0]     aad_cnt_q;
  logic [LEN_W-1:0]     data_cnt_q;
  logic [4:0]           eff_bytes;
  logic [GCM_BLK_W-1:0] pad_block;
  logic [GCM_BLK_W-1:0] len_block;
  logic [LEN_W:0]       aad_sum;
  logic [LEN_W:0]       data_sum;
  logic [LEN_W-1:0]     aad_next;
  logic [LEN_W-1:0]     data_next;

  // Out-of-range byte counts are treated as a full beat.
  assign eff_bytes = (in_bytes == 5'd0 || in_bytes > 5'd16) ? 5'd16 : in_bytes;

  gcm_byte_pad u_pad (
    .data    (in_data),
    .n_bytes (eff_bytes),
    .block   (pad_block)
  );

  assign aad_sum   = {1'b0, aad_cnt_q}  + {{(LEN_W-4){1'b0}}, eff_bytes};
  assign data_sum  = {1'b0, data_cnt_q} + {{(LEN_W-4){1'b0}}, eff_bytes};
  assign aad_next  = aad_sum[LEN_W]  ? '1 : aad_sum[LEN_W-1:0];
  assign data_next = data_sum[LEN_W] ? '1 : data_sum[LEN_W-1:0];
  assign len_block = gcm_len_block(64'(aad_cnt_q), 64'(data_cnt_q));

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      FEED_AAD:      in_ready = in_valid && in_is_aad;
      FEED_DATA_ANN: in_ready = !ann_ph_q;
      FEED_DATA:     in_ready = 1'b1;
      default:       in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FEED_IDLE;
      empty_q       <= 1'b0;
      ann_ph_q      <= 1'b0;
      ann_last_q    <= 1'b0;
      aad_cnt_q     <= '0;
      data_cnt_q    <= '0;
      gh_start      <= 1'b0;
      gh_aad_valid  <= 1'b0;
      gh_data_valid <= 1'b0;
      gh_final      <= 1'b0;
      gh_block      <= '0;
      busy          <= 1'b0;
      op_done       <= 1'b0;
    end else begin
      gh_start <= 1'b0;
      op_done  <= 1'b0;
      case (state_q)
        FEED_IDLE: begin
          gh_aad_valid  <= 1'b0;
          gh_data_valid <= 1'b0;
          gh_final      <= 1'b0;
          if (op_start) begin
            aad_cnt_q  <= '0;
            data_cnt_q <= '0;
            empty_q    <= op_empty;
            busy       <= 1'b1;
            gh_start   <= 1'b1;
            state_q    <= FEED_START;
          end
        end
        FEED_START: begin
          state_q <= empty_q ? FEED_LEN_ANN : FEED_AAD;
        end
        FEED_AAD: begin
          gh_aad_valid <= 1'b0;
          if (in_valid && in_is_aad) begin
            aad_cnt_q    <= aad_next;
            gh_aad_valid <= 1'b1;
            gh_block     <= pad_block;
            if (in_last) state_q <= FEED_LEN_ANN;
          end else if (in_valid) begin
            ann_ph_q <= 1'b0;
            state_q  <= FEED_DATA_ANN;
          end
        end
        FEED_DATA_ANN: begin
          gh_aad_valid <= 1'b0;
          if (!ann_ph_q) begin
            if (in_valid) begin
              data_cnt_q    <= data_next;
              gh_data_valid <= 1'b1;
              gh_block      <= pad_block;
              ann_last_q    <= in_last;
              ann_ph_q      <= 1'b1;
            end
          end else begin
            // Second presentation of the same block; gcm_ghash absorbs this one.
            ann_ph_q <= 1'b0;
            state_q  <= ann_last_q ? FEED_LEN_ANN : FEED_DATA;
          end
        end
        FEED_DATA: begin
          gh_data_valid <= in_valid;
          if (in_valid) begin
            data_cnt_q <= data_next;
            gh_block   <= pad_block;
            if (in_last) state_q <= FEED_LEN_ANN;
          end
        end
        FEED_LEN_ANN: begin
          gh_aad_valid  <= 1'b0;
          gh_data_valid <= 1'b0;
          gh_final      <= 1'b1;
          gh_block      <= len_block;
          state_q       <= FEED_LEN;
        end
        FEED_LEN: begin
          gh_final <= 1'b1;
          state_q  <= FEED_WAIT_TAG;
        end
        FEED_WAIT_TAG: begin
          gh_final <= 1'b0;
          if (gh_tag_valid) begin
            op_done <= 1'b1;
            busy    <= 1'b0;
            state_q <= FEED_IDLE;
          end
        end
        default: state_q <= FEED_IDLE;
      endcase
    end
  end

`ifdef GCM_FEED_PROTO_CHECK_EN
  logic err_q;
  logic accept;
  logic data_phase;
  logic bad_bytes;
  logic short_mid;
  logic late_aad;
  logic sat_hit;

  assign accept     = in_valid && in_ready;
  assign data_phase = (state_q == FEED_DATA_ANN) || (state_q == FEED_DATA);
  assign bad_bytes  = (in_bytes == 5'd0) || (in_bytes > 5'd16);
  assign short_mid  = data_phase && (in_bytes < 5'd16) && !in_last;
  assign late_aad   = data_phase && in_is_aad;
  assign sat_hit    = data_phase ? data_sum[LEN_W] : aad_sum[LEN_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == FEED_IDLE && op_start) begin
      err_q <= 1'b0;
    end else if (accept && (bad_bytes || short_mid || late_aad || sat_hit)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_ghash_feeder.sv
// Scoreboard bench for gcm_ghash_feeder: expected gh_* cycles are queued as
// beats are driven and popped by a negedge monitor.
module tb_gcm_ghash_feeder;
  import gcm_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_start = 1'b0;
  logic         op_empty = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [4:0]   in_bytes = '0;
  logic         in_is_aad = 1'b0;
  logic         in_last = 1'b0;
  logic         gh_start, gh_aad_valid, gh_data_valid, gh_final;
  logic [127:0] gh_block;
  logic         gh_tag_valid = 1'b0;
  logic         busy, op_done, err;

  always #5 clk = ~clk;

  gcm_ghash_feeder #(.LEN_W(36)) dut (
    .clk(clk), .rst_n(rst_n), .op_start(op_start), .op_empty(op_empty),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bytes(in_bytes),
    .in_is_aad(in_is_aad), .in_last(in_last), .gh_start(gh_start),
    .gh_aad_valid(gh_aad_valid), .gh_data_valid(gh_data_valid), .gh_final(gh_final),
    .gh_block(gh_block), .gh_tag_valid(gh_tag_valid), .busy(busy), .op_done(op_done),
    .err(err)
  );

`ifdef GCM_FEED_PROTO_CHECK_EN
  localparam logic ERR_ON_BAD = 1'b1;
`else
  localparam logic ERR_ON_BAD = 1'b0;
`endif

  localparam logic [3:0] K_START = 4'b1000;
  localparam logic [3:0] K_AAD   = 4'b0100;
  localparam logic [3:0] K_DATA  = 4'b0010;
  localparam logic [3:0] K_FINAL = 4'b0001;

  typedef struct {
    logic [3:0]   kind;
    logic [127:0] blk;
    bit           consec;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_tests = 0;
  int         n_fail = 0;
  int         data_seen = 0;
  bit         mon_en = 1'b0;
  logic       prev_any = 1'b0;
  logic       prev_start = 1'b0;
  logic [3:0] obs_kind;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] pad_model(input logic [127:0] d, input int n);
    logic [127:0] ones;
    int m;
    ones = '1;
    m = (n == 0 || n > 16) ? 16 : n;
    return d & ~(ones >> (8 * m));
  endfunction

  function automatic logic [127:0] len_model(input longint a, input longint d);
    return {64'(a) << 3, 64'(d) << 3};
  endfunction

  task automatic push(input logic [3:0] k, input logic [127:0] b, input bit c);
    exp_t t;
    t.kind = k;
    t.blk = b;
    t.consec = c;
    sb.push_back(t);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs_kind = {gh_start, gh_aad_valid, gh_data_valid, gh_final};
      if (gh_data_valid) data_seen++;
      if (obs_kind != 4'b0) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra", obs_kind, 0);
        end else begin
          e = sb.pop_front();
          check_eq("kind", obs_kind, e.kind);
          if (e.kind != K_START) check_eq("block", gh_block, e.blk);
          if (e.consec) check_eq("consec", prev_any, 1);
        end
        if (gh_aad_valid) check_eq("start_gap", prev_start, 0);
      end
      prev_any = |obs_kind;
      prev_start = gh_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit empty);
    op_start = 1'b1;
    op_empty = empty;
    push(K_START, '0, 1'b0);
    data_seen = 0;
    tick();
    op_start = 1'b0;
    op_empty = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input int n, input bit aad, input bit last,
                           input logic [127:0] want, input int copies);
    bit got;
    got = 1'b0;
    in_data = d;
    in_bytes = 5'(n);
    in_is_aad = aad;
    in_last = last;
    in_valid = 1'b1;
    push(aad ? K_AAD : K_DATA, want, 1'b0);
    if (copies == 2) push(K_DATA, want, 1'b1);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) check_eq("ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic finish_op(input logic [127:0] want_len, input logic want_err);
    bit drained;
    drained = 1'b0;
    push(K_FINAL, want_len, 1'b0);
    push(K_FINAL, want_len, 1'b1);
    for (int k = 0; k < 60 && !drained; k++) begin
      @(negedge clk);
      drained = (sb.size() == 0);
    end
    check_eq("drain", sb.size(), 0);
    tick();
    check_eq("busy_wait", busy, 1);
    gh_tag_valid = 1'b1;
    tick();
    gh_tag_valid = 1'b0;
    @(negedge clk);
    check_eq("op_done", op_done, 1);
    check_eq("busy_clr", busy, 0);
    @(negedge clk);
    check_eq("op_done_pulse", op_done, 0);
    check_eq("err", err, want_err);
    tick();
  endtask

  logic [127:0] d0, d1, d2, d3;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    d0 = 128'h000102030405060708090a0b0c0d0e0f;
    d1 = 128'ha1a2a3a4b5b6b7b8c9cacbccdddedfe0;
    d2 = 128'h1111222233334444555566667777aaaa;
    d3 = 128'hfedcba98765432100123456789abcdef;

    repeat (2) @(negedge clk);
    check_eq("rst_outs", {gh_start, gh_aad_valid, gh_data_valid, gh_final, op_done, busy, in_ready}, 0);
    check_eq("rst_block", gh_block, 0);
    check_eq("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Empty message
    start_op(1'b1);
    finish_op(128'h0, 1'b0);

    // AAD 16+4, data 32
    start_op(1'b0);
    check_eq("busy_set", busy, 1);
    send_beat(d0, 16, 1'b1, 1'b0, d0, 1);
    send_beat(d1, 4, 1'b1, 1'b0, {d1[127:96], 96'h0}, 1);
    send_beat(d2, 16, 1'b0, 1'b0, d2, 2);
    send_beat(d3, 16, 1'b0, 1'b1, d3, 1);
    finish_op({64'd160, 64'd256}, 1'b0);
    check_eq("data_seen_ad", data_seen, 3);

    // AAD only
    start_op(1'b0);
    send_beat(d3, 16, 1'b1, 1'b1, d3, 1);
    finish_op({64'd128, 64'd0}, 1'b0);
    check_eq("data_seen_aad_only", data_seen, 0);

    // Data only, 1010 bubbles, op_start while busy
    start_op(1'b0);
    send_beat(d0, 16, 1'b0, 1'b0, d0, 2);
    tick();
    send_beat(d1, 16, 1'b0, 1'b0, d1, 1);
    op_start = 1'b1;
    op_empty = 1'b1;
    tick();
    op_start = 1'b0;
    op_empty = 1'b0;
    send_beat(d2, 16, 1'b0, 1'b0, d2, 1);
    tick();
    send_beat(d3, 5, 1'b0, 1'b1, pad_model(d3, 5), 1);
    finish_op(len_model(0, 53), 1'b0);
    check_eq("data_seen_bubble", data_seen, 5);

    // Reset mid-DATA
    start_op(1'b0);
    send_beat(d0, 16, 1'b1, 1'b0, d0, 1);
    send_beat(d1, 16, 1'b0, 1'b0, d1, 2);
    send_beat(d2, 16, 1'b0, 1'b0, d2, 1);
    mon_en = 1'b0;
    sb.delete();
    in_data = d3;
    in_bytes = 5'd16;
    in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_outs", {gh_start, gh_aad_valid, gh_data_valid, gh_final, op_done, busy, in_ready}, 0);
    check_eq("midrst_block", gh_block, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    prev_any = 1'b0;
    prev_start = 1'b0;
    mon_en = 1'b1;

    // in_bytes == 0 (error when the checker is built in)
    start_op(1'b0);
    send_beat(d1, 0, 1'b1, 1'b1, pad_model(d1, 0), 1);
    finish_op({64'd128, 64'd0}, ERR_ON_BAD);
    repeat (3) tick();
    check_eq("err_sticky", err, ERR_ON_BAD);

    // Next op clears err
    start_op(1'b1);
    finish_op(128'h0, 1'b0);

    check_eq("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
